// File: rtl/count_monitor_if.sv
// Capture-FIFO output stream: head data/valid from the monitor, ready from the consumer.
interface count_monitor_if #(
    parameter int unsigned WRAP_W = 4
) ();
    logic              out_valid;
    logic              out_ready;
    logic [WRAP_W+3:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/count_monitor.sv
// Watches an upstream 4-bit counter, counts 15->0 wraps (saturating) and queues
// {wrap_count, counter_in} snapshots on request in a small FIFO with a registered head.
module count_monitor #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WRAP_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [3:0]               counter_in,
    input  logic                     capture,
    output logic [WRAP_W-1:0]        wrap_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    count_monitor_if.master          stream
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned DATA_W = WRAP_W + 4;

    logic [3:0]        prev_count;
    logic              prev_valid;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrap_c;
    logic              pop_c;
    logic              push_c;
    logic              full_c;
    logic [DATA_W-1:0] push_data_c;
    logic [PTR_W-1:0]  rd_next_c;
    logic [LVL_W-1:0]  level_next_c;

    // Wrap detection, handshake decode and next occupancy
    always_comb begin
        wrap_c       = prev_valid && enable && (prev_count == 4'hF) && (counter_in == 4'h0);
        pop_c        = stream.out_valid && stream.out_ready;
        full_c       = (fifo_level == LVL_W'(DEPTH));
        push_c       = capture && (!full_c || pop_c);
        push_data_c  = {wrap_count, counter_in};
        rd_next_c    = rd_ptr + PTR_W'(1);
        level_next_c = fifo_level;
        if (push_c && !pop_c) begin
            level_next_c = fifo_level + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_next_c = fifo_level - LVL_W'(1);
        end
    end

    // Control state, counters and the registered FIFO head
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_count       <= 4'h0;
            prev_valid       <= 1'b0;
            wrap_count       <= '0;
            overflow         <= 1'b0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            fifo_level       <= '0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
        end else begin
            prev_count <= counter_in;
            prev_valid <= 1'b1;
            if (wrap_c && (wrap_count != '1)) begin
                wrap_count <= wrap_count + WRAP_W'(1);
            end
            if (capture && !push_c) begin
                overflow <= 1'b1;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_next_c;
            end
            fifo_level       <= level_next_c;
            stream.out_valid <= (level_next_c != '0);
            // Head follows the push when the queue was (or becomes) empty, else the next stored entry
            if (push_c && ((fifo_level == '0) || (pop_c && (fifo_level == LVL_W'(1))))) begin
                stream.out_data <= push_data_c;
            end else if (pop_c && (fifo_level > LVL_W'(1))) begin
                stream.out_data <= mem[rd_next_c];
            end
        end
    end

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clock) begin
        if (!reset && push_c) begin
            mem[wr_ptr] <= push_data_c;
        end
    end
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_count_monitor;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WRAP_W = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] counter_in;
    logic       capture;
    logic [WRAP_W-1:0] wrap_count;
    logic [$clog2(DEPTH):0] fifo_level;
    logic       overflow;

    count_monitor_if #(.WRAP_W(WRAP_W)) stream ();

    count_monitor #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .counter_in (counter_in),
        .capture    (capture),
        .wrap_count (wrap_count),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .stream     (stream)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: wrap counter as an integer, FIFO as a queue
    logic [7:0] mq[$];
    int  m_wc  = 0;
    bit  m_ovf = 1'b0;
    bit  m_pv  = 1'b0;
    int  m_pc  = 0;
    bit  m_wrap, m_pop, m_acc;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_wc  = 0;
            m_ovf = 1'b0;
            m_pv  = 1'b0;
        end else begin
            m_wrap = m_pv && enable && (m_pc == 15) && (counter_in == 4'd0);
            m_pop  = (mq.size() > 0) && stream.out_ready;
            m_acc  = capture && ((mq.size() < DEPTH) || m_pop);
            if (capture && !m_acc) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back({4'(m_wc), counter_in});
            if (m_wrap && (m_wc < (1 << WRAP_W) - 1)) m_wc++;
            m_pv = 1'b1;
        end
        m_pc = int'(counter_in);
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            chk("m_out_valid",  32'(stream.out_valid), 32'(mq.size() != 0));
            chk("m_fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("m_wrap_count", 32'(wrap_count), 32'(m_wc));
            chk("m_overflow",   32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) chk("m_out_data", 32'(stream.out_data), 32'(mq[0]));
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wrap_count"}, 32'(wrap_count), 32'd0);
        chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_out_valid"},  32'(stream.out_valid), 32'd0);
        chk({tag, "_overflow"},   32'(overflow), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; counter_in = 4'hF; capture = 1'b0;
        stream.out_ready = 1'b1;
        cyc(); cyc();
        cmp_on = 1'b1;
        check_idle("reset");

        // 15 -> 0 straddling reset release must not count
        reset = 1'b0; enable = 1'b1; counter_in = 4'h0;
        cyc();
        chk("first_edge_no_wrap", 32'(wrap_count), 32'd0);
        counter_in = 4'hF; cyc();
        enable = 1'b0; counter_in = 4'h0; cyc();
        chk("disabled_no_wrap", 32'(wrap_count), 32'd0);
        enable = 1'b1;

        // Two full sweeps
        do_reset();
        stream.out_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 16; v++) begin
                counter_in = 4'(v); cyc();
            end
        end
        counter_in = 4'h0; cyc();
        chk("sweep_wrap_count", 32'(wrap_count), 32'd2);
        counter_in = 4'hF; cyc();
        counter_in = 4'h0; cyc();
        chk("third_wrap", 32'(wrap_count), 32'd3);

        // Single capture, held while not ready
        counter_in = 4'h7; capture = 1'b1; cyc();
        capture = 1'b0;
        chk("cap_valid", 32'(stream.out_valid), 32'd1);
        chk("cap_data",  32'(stream.out_data), 32'h37);
        chk("cap_level", 32'(fifo_level), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("cap_hold", 32'(stream.out_data), 32'h37);
        end
        stream.out_ready = 1'b1; cyc();
        stream.out_ready = 1'b0;
        chk("cap_popped_level", 32'(fifo_level), 32'd0);

        // Five captures into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            counter_in = 4'(i); capture = 1'b1; cyc();
        end
        capture = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_overflow", 32'(overflow), 32'd1);
        stream.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(stream.out_data), 32'h30 + 32'(i));
            cyc();
        end
        chk("drained_level", 32'(fifo_level), 32'd0);
        stream.out_ready = 1'b0;
        cyc();
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 10; i <= 13; i++) begin
            counter_in = 4'(i); capture = 1'b1; cyc();
        end
        counter_in = 4'hE; stream.out_ready = 1'b1; cyc();
        capture = 1'b0;
        chk("pushpop_level", 32'(fifo_level), 32'd4);
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        for (int i = 11; i <= 14; i++) begin
            chk("pushpop_order", 32'(stream.out_data), 32'(i));
            cyc();
        end
        chk("pushpop_empty", 32'(stream.out_valid), 32'd0);
        cyc();
        chk("ready_on_empty", 32'(fifo_level), 32'd0);
        stream.out_ready = 1'b0;

        // Saturation, then reset with entries queued
        do_reset();
        for (int i = 0; i < 17; i++) begin
            counter_in = 4'hF; cyc();
            counter_in = 4'h0; cyc();
        end
        chk("saturated", 32'(wrap_count), 32'd15);
        counter_in = 4'h5; capture = 1'b1; cyc(); cyc();
        capture = 1'b0;
        chk("queued_two", 32'(fifo_level), 32'd2);
        chk("queued_head", 32'(stream.out_data), 32'hF5);
        capture = 1'b1; stream.out_ready = 1'b1;
        reset = 1'b1; cyc();
        reset = 1'b0; capture = 1'b0; stream.out_ready = 1'b0;
        check_idle("midreset");
        cyc();
        check_idle("post_reset");

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
